// File: rtl/product_acc_pkg.sv
// Shared types and default sizing for the product accumulation stage.
package product_acc_pkg;

  localparam int PW_DEF    = 8;
  localparam int FRAME_DEF = 4;
  localparam int ACC_W_DEF = 10;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: ACC_W-bit accumulator plus PW-bit addend, clamped to all-ones.
module sat_add #(
  parameter int ACC_W = 10,
  parameter int PW    = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [PW-1:0]    add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W:0] full_sum;

  // One extra bit holds the carry; PW <= ACC_W keeps the zero-pad width positive.
  assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PW){1'b0}}, add_i};
  assign ovf_o    = full_sum[ACC_W];
  assign sum_o    = ovf_o ? '1 : full_sum[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums fixed-length frames of products into a saturating total, presented on a valid/ready port.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int FRAME = FRAME_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [PW-1:0]    product_i,
  input  logic             product_valid_i,
  output logic             in_ready_o,
  output logic [ACC_W-1:0] sum_o,
  output logic             sum_valid_o,
  input  logic             out_ready_i,
  output logic             overflow_o,
  output logic [3:0]       count_o
);

  localparam logic [3:0] LAST_CNT = 4'(FRAME - 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;

  sat_add #(
    .ACC_W(ACC_W),
    .PW   (PW)
  ) u_sat_add (
    .acc_i(acc_q),
    .add_i(product_i),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  assign in_ready_o = (state_q == ACCUM);
  assign accept     = product_valid_i && in_ready_o;

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    if (clear_i) begin
      state_d  = ACCUM;
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (cnt_q == LAST_CNT) begin
              sum_d    = add_sum;
              ovf_d    = sticky_q | add_ovf;
              acc_d    = '0;
              cnt_d    = '0;
              sticky_d = 1'b0;
              state_d  = HOLD;
            end else begin
              acc_d    = add_sum;
              cnt_d    = cnt_q + 4'd1;
              sticky_d = sticky_q | add_ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum_valid_o = (state_q == HOLD);
  assign sum_o       = sum_q;
  assign overflow_o  = ovf_q;
  assign count_o     = cnt_q;

endmodule
